// File: rtl/cfg_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_reg_pkg                                                   |
// | Purpose  : Shared constants and types for the cfg_reg_block register     |
// |            file: register byte offsets, CTRL bit positions, bus FSM      |
// |            state type and the per-bit write-enable merge helper.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cfg_reg_pkg;

  localparam int REG_W = 32;

  // Register byte offsets
  localparam logic [7:0] ADDR_ID       = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_EN   = 8'h10;
  localparam logic [7:0] ADDR_COUNT    = 8'h14;
  localparam logic [7:0] ADDR_SCRATCH  = 8'h18;

  // CTRL bit positions
  localparam int CTRL_COUNT_EN = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } cfg_state_t;

  // Only bits with their write enable set take the new value.
  function automatic logic [REG_W-1:0] apply_biten(
    input logic [REG_W-1:0] old_val,
    input logic [REG_W-1:0] wdata,
    input logic [REG_W-1:0] biten
  );
    return (old_val & ~biten) | (wdata & biten);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_irq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_irq_ctrl                                                  |
// | Purpose  : Interrupt status (W1C) and enable registers plus the          |
// |            registered level interrupt.                                   |
// | Ports    : clk, rst (async, active low)                                  |
// |            hw_evt   - event pulses, one status bit each                  |
// |            wrap_evt - counter wrap, top status bit                       |
// |            stat_we  - W1C write to status this cycle                     |
// |            en_we    - masked write to enable this cycle                  |
// |            wr_data / wr_biten - implemented slice of the bus write       |
// |            irq_stat / irq_en  - register contents for read-back          |
// |            irq_o    - |(stat & en), one cycle behind the registers       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cfg_irq_ctrl #(
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] hw_evt,
  input  logic               wrap_evt,
  input  logic               stat_we,
  input  logic               en_we,
  input  logic [NUM_EVT:0]   wr_data,
  input  logic [NUM_EVT:0]   wr_biten,
  output logic [NUM_EVT:0]   irq_stat,
  output logic [NUM_EVT:0]   irq_en,
  output logic               irq_o
);

  logic [NUM_EVT:0] r_stat;
  logic [NUM_EVT:0] r_en;
  logic             r_irq;
  logic [NUM_EVT:0] w_set;
  logic [NUM_EVT:0] w_clr;

  assign w_set = {wrap_evt, hw_evt};
  assign w_clr = stat_we ? (wr_data & wr_biten) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat <= '0;
      r_en   <= '0;
      r_irq  <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle event keeps its bit.
      r_stat <= (r_stat & ~w_clr) | w_set;
      if (en_we) begin
        r_en <= (r_en & ~wr_biten) | (wr_data & wr_biten);
      end
      r_irq <= |(r_stat & r_en);
    end
  end

  assign irq_stat = r_stat;
  assign irq_en   = r_en;
  assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: rtl/cfg_reg_block.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_reg_block                                                 |
// | Purpose  : Register file behind the APB4 bridge's internal request bus.  |
// |            ID, CTRL, STATUS, IRQ_STAT (W1C), IRQ_EN, COUNT, SCRATCH.     |
// | Ports    : clk, rst (async, active low)                                  |
// |            bus_req/bus_req_is_wr/bus_addr/bus_wr_data/bus_wr_biten in    |
// |            bus_ready (1-cycle pulse), bus_rd_data, bus_err out           |
// |            ctrl_o, count_o  - register contents                          |
// |            status_i         - live status, read at STATUS                |
// |            hw_evt_i         - event pulses into IRQ_STAT                 |
// |            irq_o            - level interrupt                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cfg_reg_block
  import cfg_reg_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 5,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_EVT     = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_req,
  input  logic                  bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wr_data,
  input  logic [DATA_WIDTH-1:0] bus_wr_biten,
  output logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_rd_data,
  output logic                  bus_err,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  input  logic [DATA_WIDTH-1:0] status_i,
  input  logic [NUM_EVT-1:0]    hw_evt_i,
  output logic                  irq_o,
  output logic [DATA_WIDTH-1:0] count_o
);

  cfg_state_t            r_state;
  logic [3:0]            r_wait_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_scratch;

  logic                  w_hit_id, w_hit_ctrl, w_hit_status, w_hit_stat;
  logic                  w_hit_en, w_hit_count, w_hit_scratch;
  logic                  w_err, w_commit, w_wr_ok, w_wrap;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [NUM_EVT:0]      w_irq_stat, w_irq_en;

  // Full-address compare: misaligned addresses and 0x1C hit nothing.
  assign w_hit_id      = (bus_addr == ADDR_WIDTH'(ADDR_ID));
  assign w_hit_ctrl    = (bus_addr == ADDR_WIDTH'(ADDR_CTRL));
  assign w_hit_status  = (bus_addr == ADDR_WIDTH'(ADDR_STATUS));
  assign w_hit_stat    = (bus_addr == ADDR_WIDTH'(ADDR_IRQ_STAT));
  assign w_hit_en      = (bus_addr == ADDR_WIDTH'(ADDR_IRQ_EN));
  assign w_hit_count   = (bus_addr == ADDR_WIDTH'(ADDR_COUNT));
  assign w_hit_scratch = (bus_addr == ADDR_WIDTH'(ADDR_SCRATCH));

  assign w_err = ~(w_hit_id | w_hit_ctrl | w_hit_status | w_hit_stat |
                   w_hit_en | w_hit_count | w_hit_scratch) |
                 (bus_req_is_wr & (w_hit_id | w_hit_status));

  // Requests are only accepted in IDLE, so each one commits exactly once.
  assign w_commit = (r_state == IDLE) & bus_req;
  assign w_wr_ok  = w_commit & bus_req_is_wr & ~w_err;

  // A bus write to COUNT overrides the increment and suppresses the wrap.
  assign w_wrap = r_ctrl[CTRL_COUNT_EN] & (&r_count) & ~(w_wr_ok & w_hit_count);

  always_comb begin
    w_rd_mux = '0;
    if (w_hit_id)           w_rd_mux = ID_VALUE;
    else if (w_hit_ctrl)    w_rd_mux = r_ctrl;
    else if (w_hit_status)  w_rd_mux = status_i;
    else if (w_hit_stat)    w_rd_mux = DATA_WIDTH'(w_irq_stat);
    else if (w_hit_en)      w_rd_mux = DATA_WIDTH'(w_irq_en);
    else if (w_hit_count)   w_rd_mux = r_count;
    else if (w_hit_scratch) w_rd_mux = r_scratch;
  end

  // Bus handshake FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_ready    <= 1'b0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus_req) begin
            r_rd_data  <= (w_err | bus_req_is_wr) ? '0 : w_rd_mux;
            r_err      <= w_err;
            r_wait_cnt <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES > 0) begin
              r_state <= WAIT;
            end else begin
              r_state <= RESP;
              r_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (r_wait_cnt <= 4'd1) begin
            r_state <= RESP;
            r_ready <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_rd_data <= '0;
          r_err     <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // CTRL, COUNT, SCRATCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl    <= '0;
      r_count   <= '0;
      r_scratch <= '0;
    end else begin
      if (w_wr_ok & w_hit_ctrl) begin
        r_ctrl <= apply_biten(r_ctrl, bus_wr_data, bus_wr_biten);
      end
      if (w_wr_ok & w_hit_scratch) begin
        r_scratch <= apply_biten(r_scratch, bus_wr_data, bus_wr_biten);
      end
      if (w_wr_ok & w_hit_count) begin
        r_count <= apply_biten(r_count, bus_wr_data, bus_wr_biten);
      end else if (r_ctrl[CTRL_COUNT_EN]) begin
        r_count <= r_count + DATA_WIDTH'(1);
      end
    end
  end

  cfg_irq_ctrl #(
    .NUM_EVT (NUM_EVT)
  ) u_irq_ctrl (
    .clk      (clk),
    .rst      (rst),
    .hw_evt   (hw_evt_i),
    .wrap_evt (w_wrap),
    .stat_we  (w_wr_ok & w_hit_stat),
    .en_we    (w_wr_ok & w_hit_en),
    .wr_data  (bus_wr_data[NUM_EVT:0]),
    .wr_biten (bus_wr_biten[NUM_EVT:0]),
    .irq_stat (w_irq_stat),
    .irq_en   (w_irq_en),
    .irq_o    (irq_o)
  );

  assign bus_ready   = r_ready;
  assign bus_rd_data = r_rd_data;
  assign bus_err     = r_err;
  assign ctrl_o      = r_ctrl;
  assign count_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cfg_reg_block.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cfg_reg_block                                              |
// | Purpose  : Self-checking bench for cfg_reg_block. u_dut0 (no wait        |
// |            states) is tracked cycle by cycle against a register-map      |
// |            model; u_dut3 (three wait states) covers latency and reset    |
// |            during a wait.                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cfg_reg_block;

  localparam logic [31:0] STAT_MASK = 32'h0000_01FF;  // 8 events + wrap bit

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;        // 0: requests go to u_dut0, 1: to u_dut3
  logic        bus_req = 1'b0;
  logic        bus_req_is_wr = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wr_data = '0;
  logic [31:0] bus_wr_biten = '0;
  logic [31:0] status_i = '0;
  logic [7:0]  hw_evt_i = '0;

  logic        req0, req3;
  logic        rdy0, err0, irq0, rdy3, err3, irq3;
  logic [31:0] rdata0, ctrl0, cnt0, rdata3, ctrl3, cnt3;

  assign req0 = bus_req & ~sel;
  assign req3 = bus_req & sel;

  always #5 clk = ~clk;

  cfg_reg_block #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus_req(req0), .bus_req_is_wr(bus_req_is_wr),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_ready(rdy0), .bus_rd_data(rdata0), .bus_err(err0), .ctrl_o(ctrl0),
    .status_i(status_i), .hw_evt_i(hw_evt_i), .irq_o(irq0), .count_o(cnt0)
  );

  cfg_reg_block #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus_req(req3), .bus_req_is_wr(bus_req_is_wr),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_ready(rdy3), .bus_rd_data(rdata3), .bus_err(err3), .ctrl_o(ctrl3),
    .status_i(status_i), .hw_evt_i(hw_evt_i), .irq_o(irq3), .count_o(cnt3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of u_dut0's architectural registers
  logic [31:0] m_ctrl, m_scratch, m_count, m_stat, m_en;
  logic        m_irq;
  logic [31:0] exp_rd;
  logic        exp_err;
  logic [31:0] cnt_commit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_scratch = '0; m_count = '0; m_stat = '0; m_en = '0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v);
    return (old_v & ~bus_wr_biten) | (bus_wr_data & bus_wr_biten);
  endfunction

  // One clock cycle. commit=1 means u_dut0 takes the current request now.
  task automatic tick(input bit commit);
    int          idx;
    logic [31:0] n_ctrl, n_scr, n_cnt, n_en, n_stat, set_m, clr_m;
    logic        n_irq, wr_ok;
    idx     = int'(bus_addr[4:2]);
    exp_err = (bus_addr[1:0] != 2'b00) || (idx == 7) ||
              (bus_req_is_wr && (idx == 0 || idx == 2));
    exp_rd  = '0;
    if (!exp_err && !bus_req_is_wr) begin
      case (idx)
        0: exp_rd = 32'hC0DE_0001;
        1: exp_rd = m_ctrl;
        2: exp_rd = status_i;
        3: exp_rd = m_stat;
        4: exp_rd = m_en;
        5: exp_rd = m_count;
        6: exp_rd = m_scratch;
        default: exp_rd = '0;
      endcase
    end
    wr_ok  = commit && bus_req_is_wr && !exp_err;
    n_ctrl = m_ctrl; n_scr = m_scratch; n_en = m_en; clr_m = '0;
    n_cnt  = m_ctrl[0] ? m_count + 32'd1 : m_count;
    set_m  = {24'd0, hw_evt_i};
    if (m_ctrl[0] && m_count == 32'hFFFF_FFFF) set_m[8] = 1'b1;
    if (wr_ok) begin
      case (idx)
        1: n_ctrl = merge(m_ctrl);
        3: clr_m  = bus_wr_data & bus_wr_biten;
        4: n_en   = merge(m_en) & STAT_MASK;
        5: begin n_cnt = merge(m_count); set_m[8] = 1'b0; end
        6: n_scr  = merge(m_scratch);
        default: ;
      endcase
    end
    n_stat = ((m_stat & ~clr_m) | set_m) & STAT_MASK;
    n_irq  = |(m_stat & m_en);
    @(posedge clk);
    #1;
    if (rst) begin
      m_ctrl = n_ctrl; m_scratch = n_scr; m_count = n_cnt;
      m_stat = n_stat; m_en = n_en; m_irq = n_irq;
    end else begin
      model_reset();
    end
    check("ctrl_o", ctrl0, m_ctrl);
    check("count_o", cnt0, m_count);
    check("irq_o", irq0, m_irq);
  endtask

  // Transaction on u_dut0: commit cycle, then the ready cycle.
  task automatic xact0(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] be, output logic [31:0] rd, output logic er);
    sel = 1'b0; bus_req = 1'b1; bus_req_is_wr = wr; bus_addr = a;
    bus_wr_data = wd; bus_wr_biten = be;
    check("ready_before_commit", rdy0, 1'b0);
    tick(1'b1);
    check("ready", rdy0, 1'b1);
    check("rd_data", rdata0, exp_rd);
    check("err", err0, exp_err);
    rd = rdata0; er = err0; cnt_commit = cnt0;
    tick(1'b0);  // request still held: must not commit again
    bus_req = 1'b0;
    check("ready_single_pulse", rdy0, 1'b0);
  endtask

  // Transaction on u_dut3; bounded wait for ready, counts ready pulses.
  task automatic xact3(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] be, output logic [31:0] rd,
                       output logic er, output int lat, output int npulse);
    bit drop;
    sel = 1'b1; bus_req = 1'b1; bus_req_is_wr = wr; bus_addr = a;
    bus_wr_data = wd; bus_wr_biten = be;
    lat = -1; npulse = 0; rd = '0; er = 1'b0; drop = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0);
      if (drop) begin bus_req = 1'b0; drop = 1'b0; end
      if (rdy3) begin
        npulse++;
        if (lat < 0) begin lat = i; rd = rdata3; er = err3; drop = 1'b1; end
      end
    end
    bus_req = 1'b0;
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, np;
    logic [4:0]  bad_addr [3];

    model_reset();

    // ---- Reset state ----
    tick(1'b0);
    tick(1'b0);
    check("rst_ready", rdy0, 1'b0);
    check("rst_rd_data", rdata0, 32'h0);
    check("rst_err", err0, 1'b0);
    check("rst_ready3", rdy3, 1'b0);
    rst = 1'b1;
    tick(1'b0);

    xact0(1'b0, 5'h00, '0, '0, rd, er);
    check("id_value", rd, 32'hC0DE_0001);
    check("id_err", er, 1'b0);

    // ---- Masked write and error responses ----
    xact0(1'b1, 5'h18, 32'hFFFF_FFFF, 32'h0000_FFFF, rd, er);
    xact0(1'b0, 5'h18, '0, '0, rd, er);
    check("scratch_masked", rd, 32'h0000_FFFF);
    bad_addr[0] = 5'h08; bad_addr[1] = 5'h1C; bad_addr[2] = 5'h05;
    for (int i = 0; i < 3; i++) begin
      xact0(1'b1, bad_addr[i], 32'h1234_5678, 32'hFFFF_FFFF, rd, er);
      check("bad_write_err", er, 1'b1);
    end
    xact0(1'b0, 5'h18, '0, '0, rd, er);
    check("scratch_after_errors", rd, 32'h0000_FFFF);

    // ---- Interrupt path ----
    xact0(1'b1, 5'h10, 32'h3, 32'hFFFF_FFFF, rd, er);
    hw_evt_i = 8'h02;
    tick(1'b0);
    hw_evt_i = 8'h00;
    check("irq_lags_status", irq0, 1'b0);
    tick(1'b0);
    check("irq_raised", irq0, 1'b1);
    xact0(1'b0, 5'h0C, '0, '0, rd, er);
    check("irq_stat_evt1", rd, 32'h2);
    hw_evt_i = 8'h02;
    xact0(1'b1, 5'h0C, 32'h2, 32'hFFFF_FFFF, rd, er);
    hw_evt_i = 8'h00;
    xact0(1'b0, 5'h0C, '0, '0, rd, er);
    check("set_beats_clear", rd, 32'h2);
    xact0(1'b1, 5'h0C, 32'h2, 32'hFFFF_FFFF, rd, er);
    tick(1'b0);
    check("irq_cleared", irq0, 1'b0);

    // ---- Counter wrap and write priority ----
    xact0(1'b1, 5'h14, 32'hFFFF_FFFE, 32'hFFFF_FFFF, rd, er);
    xact0(1'b1, 5'h04, 32'h1, 32'hFFFF_FFFF, rd, er);
    tick(1'b0);
    check("count_wrapped", cnt0, 32'h0);
    xact0(1'b0, 5'h0C, '0, '0, rd, er);
    check("wrap_bit", rd, 32'h100);
    xact0(1'b1, 5'h14, 32'h10, 32'hFFFF_FFFF, rd, er);
    check("count_load_priority", cnt_commit, 32'h10);

    // ---- Wait states (u_dut3) ----
    xact3(1'b1, 5'h04, 32'h0000_00A2, 32'hFFFF_FFFF, rd, er, lat, np);
    check("wait_latency_wr", lat, 4);
    check("wait_single_pulse", np, 1);
    check("wait_wr_err", er, 1'b0);
    check("wait_ctrl_o", ctrl3, 32'h0000_00A2);
    xact3(1'b0, 5'h04, '0, '0, rd, er, lat, np);
    check("wait_latency_rd", lat, 4);
    check("wait_rd_data", rd, 32'h0000_00A2);

    // ---- Async reset in the middle of a wait ----
    sel = 1'b1; bus_req = 1'b1; bus_req_is_wr = 1'b1; bus_addr = 5'h18;
    bus_wr_data = 32'h5A5A_5A5A; bus_wr_biten = 32'hFFFF_FFFF;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    bus_req = 1'b0;
    model_reset();
    #1;
    check("rst_async_ctrl3", ctrl3, 32'h0);
    check("rst_async_ready3", rdy3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      check("rst_no_ready3", rdy3, 1'b0);
    end
    rst = 1'b1;
    tick(1'b0);
    check("rst_no_ready3_after", rdy3, 1'b0);
    xact3(1'b0, 5'h18, '0, '0, rd, er, lat, np);
    check("post_rst_latency", lat, 4);
    check("post_rst_scratch", rd, 32'h0);
    check("post_rst_err", er, 1'b0);

    // ---- Randomized traffic on u_dut0 against the model ----
    for (int t = 0; t < 80; t++) begin
      logic [4:0]  a;
      logic [31:0] be;
      a  = {3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = 5'($urandom);
      be = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      status_i = $urandom;
      hw_evt_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      xact0(1'($urandom), a, $urandom, be, rd, er);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        hw_evt_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        tick(1'b0);
      end
    end
    hw_evt_i = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
